// File: rtl/hc595_mon_pkg.sv
// Shared constants and segment decoder for the 74HC595 display-chain monitor.
package hc595_mon_pkg;

  localparam int WORD_W     = 16;
  localparam int NUM_DIGITS = 8;

  // Segment patterns as word bits [6:0] (a..g, a in bit 6).
  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  localparam logic [3:0] CODE_DASH    = 4'hF;
  localparam logic [3:0] CODE_UNKNOWN = 4'hE;

  typedef struct packed {
    logic       err;
    logic [3:0] code;
  } seg_dec_t;

  // Map a segment pattern back to its digit code; unknown patterns flag err.
  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t r;
    r.err  = 1'b0;
    r.code = CODE_UNKNOWN;
    case (seg)
      SEG_0:    r.code = 4'd0;
      SEG_1:    r.code = 4'd1;
      SEG_2:    r.code = 4'd2;
      SEG_3:    r.code = 4'd3;
      SEG_4:    r.code = 4'd4;
      SEG_5:    r.code = 4'd5;
      SEG_6:    r.code = 4'd6;
      SEG_7:    r.code = 4'd7;
      SEG_8:    r.code = 4'd8;
      SEG_9:    r.code = 4'd9;
      SEG_DASH: r.code = CODE_DASH;
      default:  r.err  = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hc595_display_monitor_pin_sync_edge.sv
// Pin synchronizer with a registered rising-edge detector.
// Total pin-to-rise latency is STAGES+1 clk cycles.
module pin_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  // Synchronizer chain, delayed copy and registered edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise     <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], pin};
      prev_reg <= sync_reg[STAGES-1];
      rise     <= sync_reg[STAGES-1] & ~prev_reg;
    end
  end

endmodule

// File: rtl/hc595_display_monitor.sv
// Rebuilds latched 16-bit words from the dio/sclk/rclk pins of a 74HC595
// display chain and decodes them into per-position digit codes.
module hc595_display_monitor #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dio,
  input  logic        sclk,
  input  logic        rclk,
  output logic [15:0] word_q,
  output logic        word_valid,
  output logic [31:0] digits,
  output logic [7:0]  dps,
  output logic        frame_done,
  output logic        len_err,
  output logic        sel_err,
  output logic        seg_err,
  output logic        link_active
);
  import hc595_mon_pkg::*;

  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic                  sclk_rise, rclk_rise, dio_s;
  logic [SYNC_STAGES:0]  dio_dly_reg;
  logic [WORD_W-1:0]     sh_reg;
  logic [4:0]            bit_cnt_reg;
  logic                  len_pend_reg;
  logic [TW-1:0]         tmo_cnt_reg;
  logic [7:0]            mask_reg;
  logic [3:0]            digit_reg [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] dp_reg;

  logic [2:0]            sel_idx;
  logic [3:0]            zero_cnt;
  seg_dec_t              dec;
  logic                  store;
  logic [7:0]            store_bits;
  logic [7:0]            mask_or;

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk (clk), .rst (rst), .pin (sclk), .rise (sclk_rise)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_rclk (
    .clk (clk), .rst (rst), .pin (rclk), .rise (rclk_rise)
  );

  // dio delayed by the synchronizer depth plus the edge register, so the
  // sampled bit lines up with the sclk edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dio_dly_reg <= '0;
    else     dio_dly_reg <= {dio_dly_reg[SYNC_STAGES-1:0], dio};
  end
  assign dio_s = dio_dly_reg[SYNC_STAGES];

  // Shift register, bit counter and latch of complete 16-bit words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_reg       <= '0;
      bit_cnt_reg  <= '0;
      word_q       <= '0;
      word_valid   <= 1'b0;
      len_pend_reg <= 1'b0;
    end else begin
      word_valid   <= 1'b0;
      len_pend_reg <= 1'b0;
      if (sclk_rise) sh_reg <= {sh_reg[WORD_W-2:0], dio_s};
      if (rclk_rise) begin
        // Candidate is sh_reg before any same-cycle shift; a coincident
        // bit already belongs to the next word.
        if (bit_cnt_reg == 5'd16) begin
          word_q     <= sh_reg;
          word_valid <= 1'b1;
        end else begin
          len_pend_reg <= 1'b1;
        end
        bit_cnt_reg <= sclk_rise ? 5'd1 : 5'd0;
      end else if (sclk_rise && bit_cnt_reg != 5'd17) begin
        bit_cnt_reg <= bit_cnt_reg + 5'd1;
      end
    end
  end

  // Link watchdog: counts idle cycles since the last rclk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
      link_active <= 1'b0;
    end else begin
      if (rclk_rise)                tmo_cnt_reg <= '0;
      else if (tmo_cnt_reg != TMO_MAX) tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
      if (rclk_rise && bit_cnt_reg == 5'd16) link_active <= 1'b1;
      else if (tmo_cnt_reg == TMO_MAX)       link_active <= 1'b0;
    end
  end

  // Decode the accepted word: locate the single active-low select bit.
  always_comb begin
    sel_idx  = '0;
    zero_cnt = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!word_q[8+k]) begin
        sel_idx  = 3'(k);
        zero_cnt = zero_cnt + 4'd1;
      end
    end
    dec        = seg_decode(word_q[6:0]);
    store      = word_valid && (zero_cnt == 4'd1);
    store_bits = store ? (8'b1 << sel_idx) : 8'b0;
    mask_or    = mask_reg | store_bits;
  end

  // Error pulses, frame mask and frame completion strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_err    <= 1'b0;
      sel_err    <= 1'b0;
      seg_err    <= 1'b0;
      frame_done <= 1'b0;
      mask_reg   <= '0;
    end else begin
      len_err    <= len_pend_reg;
      sel_err    <= word_valid && (zero_cnt != 4'd1);
      seg_err    <= word_valid && dec.err;
      frame_done <= 1'b0;
      if (store) begin
        if (mask_or == 8'hFF) begin
          frame_done <= 1'b1;
          mask_reg   <= (mask_reg == 8'hFF) ? store_bits : 8'h00;
        end else begin
          mask_reg <= mask_or;
        end
      end
    end
  end

  // Per-position digit and decimal point storage.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_pos
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        digit_reg[gi] <= '0;
        dp_reg[gi]    <= 1'b0;
      end else if (store_bits[gi]) begin
        digit_reg[gi] <= dec.code;
        dp_reg[gi]    <= word_q[7];
      end
    end
    assign digits[4*gi +: 4] = digit_reg[gi];
  end
  assign dps = dp_reg;

endmodule

// File: tb/tb_hc595_display_monitor.sv
// Randomized scoreboard bench for hc595_display_monitor.
module tb_hc595_display_monitor;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dio = 1'b0;
  logic        sclk = 1'b0;
  logic        rclk = 1'b0;
  logic [15:0] word_q;
  logic        word_valid;
  logic [31:0] digits;
  logic [7:0]  dps;
  logic        frame_done, len_err, sel_err, seg_err, link_active;

  always #5 clk = ~clk;

  hc595_display_monitor #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk), .rst (rst), .dio (dio), .sclk (sclk), .rclk (rclk),
    .word_q (word_q), .word_valid (word_valid), .digits (digits), .dps (dps),
    .frame_done (frame_done), .len_err (len_err), .sel_err (sel_err),
    .seg_err (seg_err), .link_active (link_active)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          accepted;
    logic [15:0] word;
    logic [31:0] digits;
    logic [7:0]  dps;
    bit          sel_err;
    bit          seg_err;
    bit          frame_done;
  } exp_t;

  exp_t sbq[$];

  // Reference model: bits since the last latch and the displayed state.
  bit         bitq[$];
  logic [3:0] m_digit [8];
  bit         m_dp    [8];
  bit         m_seen  [8];
  int exp_fd = 0, exp_sel = 0, exp_seg = 0, exp_len = 0;
  int cnt_fd = 0, cnt_sel = 0, cnt_seg = 0, cnt_len = 0;
  logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got pulse expected none", name);
  endtask

  task automatic model_clear();
    bitq.delete();
    for (int k = 0; k < 8; k++) begin
      m_digit[k] = 4'h0;
      m_dp[k]    = 1'b0;
      m_seen[k]  = 1'b0;
    end
  endtask

  // Apply the latch rules to the bits collected since the previous latch.
  task automatic model_latch();
    exp_t e;
    int zeros, pos, code;
    bit unknown, all;
    e.accepted = (bitq.size() == 16);
    e.word = '0; e.sel_err = 0; e.seg_err = 0; e.frame_done = 0;
    if (!e.accepted) begin
      exp_len++;
    end else begin
      for (int k = 0; k < 16; k++) e.word[15-k] = bitq[k];
      zeros = 0; pos = 0;
      for (int k = 0; k < 8; k++) if (!e.word[8+k]) begin zeros++; pos = k; end
      code = 14; unknown = 1;
      for (int k = 0; k < 10; k++) if (e.word[6:0] == pat[k]) begin code = k; unknown = 0; end
      if (e.word[6:0] == 7'b0000001) begin code = 15; unknown = 0; end
      e.seg_err = unknown;
      if (unknown) exp_seg++;
      if (zeros != 1) begin
        e.sel_err = 1;
        exp_sel++;
      end else begin
        m_digit[pos] = 4'(code);
        m_dp[pos]    = e.word[7];
        m_seen[pos]  = 1'b1;
        all = 1;
        for (int k = 0; k < 8; k++) if (!m_seen[k]) all = 0;
        if (all) begin
          e.frame_done = 1;
          exp_fd++;
          for (int k = 0; k < 8; k++) m_seen[k] = 1'b0;
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      e.digits[4*k +: 4] = m_digit[k];
      e.dps[k]           = m_dp[k];
    end
    bitq.delete();
    sbq.push_back(e);
  endtask

  task automatic shift_bit(input bit b);
    @(negedge clk); dio = b;
    repeat (2) @(negedge clk); sclk = 1'b1;
    repeat (2) @(negedge clk); sclk = 1'b0;
    bitq.push_back(b);
  endtask

  // Shift n bits of w MSB-first, starting 'first' bits below the MSB.
  task automatic shift_bits(input logic [15:0] w, input int first, input int n);
    for (int i = 0; i < n; i++) shift_bit(w[15-first-i]);
  endtask

  // rclk pulse, optionally with an sclk edge carrying bit b in the same cycle.
  task automatic latch(input bit with_bit, input bit b);
    @(negedge clk);
    if (with_bit) begin
      dio = b;
      repeat (2) @(negedge clk);
      sclk = 1'b1;
    end
    rclk = 1'b1;
    model_latch();
    if (with_bit) bitq.push_back(b);
    repeat (2) @(negedge clk);
    rclk = 1'b0; sclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w);
    shift_bits(w, 0, 16);
    latch(0, 0);
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 300) begin @(negedge clk); t++; end
    chk("scoreboard_drained", sbq.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_word_q"}, word_q, 0);
    chk({tag, "_word_valid"}, word_valid, 0);
    chk({tag, "_digits"}, digits, 0);
    chk({tag, "_dps"}, dps, 0);
    chk({tag, "_pulses"}, {frame_done, len_err, sel_err, seg_err}, 0);
    chk({tag, "_link_active"}, link_active, 0);
  endtask

  // Pulse counters for end-of-run totals.
  always @(negedge clk) begin
    if (!rst) begin
      cnt_fd  += int'(frame_done);
      cnt_sel += int'(sel_err);
      cnt_seg += int'(seg_err);
      cnt_len += int'(len_err);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a latch outcome.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (word_valid) begin
          if (sbq.size() == 0) fail_now("unexpected_word_valid");
          else begin
            e = sbq.pop_front();
            chk("word_valid_vs_model", word_valid, e.accepted);
            chk("word_q", word_q, e.word);
            @(negedge clk);
            chk("digits", digits, e.digits);
            chk("dps", dps, e.dps);
            chk("sel_err", sel_err, e.sel_err);
            chk("seg_err", seg_err, e.seg_err);
            chk("frame_done", frame_done, e.frame_done);
            chk("len_err_on_accept", len_err, 0);
            chk("link_active_on_accept", link_active, 1);
            $display("word %h digits %h dps %h sel_err %0d seg_err %0d frame_done %0d",
                     word_q, digits, dps, sel_err, seg_err, frame_done);
          end
        end else if (len_err) begin
          if (sbq.size() == 0) fail_now("unexpected_len_err");
          else begin
            e = sbq.pop_front();
            chk("len_err_vs_model", len_err, !e.accepted);
            chk("digits_after_len_err", digits, e.digits);
            chk("sel_seg_on_len_err", {sel_err, seg_err}, 0);
            $display("rejected latch digits %h", digits);
          end
        end
      end
    end
  end

  initial begin : stim
    logic [15:0] w;
    logic [7:0]  sel;
    logic [6:0]  seg;
    int fd0, len0, carried;
    model_clear();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send_word(16'hFE7E); drain();
    chk("single_digit0", digits[3:0], 4'h0);
    chk("single_dp0", dps[0], 0);

    send_word(16'hF7F0); drain();
    chk("dp_digit3", digits[15:12], 4'h7);
    chk("dp_dp3", dps[3], 1);
    chk("dp_link", link_active, 1);

    fd0 = cnt_fd;
    for (int i = 0; i < 8; i++) send_word({~(8'b1 << i), 1'b0, pat[i]});
    drain();
    chk("frame_digits", digits, 32'h76543210);
    chk("frame_done_once", cnt_fd - fd0, 1);

    len0 = cnt_len;
    shift_bits(16'hFE30, 0, 15); latch(0, 0); drain();
    chk("len_err_count", cnt_len - len0, 1);
    chk("len_digits_kept", digits, 32'h76543210);

    send_word(16'hFC7E); drain();
    chk("sel_digits_kept", digits, 32'h76543210);
    send_word(16'hFB00); drain();
    chk("seg_unknown_code", digits[11:8], 4'hE);

    send_word(16'h7F01); drain();
    chk("dash_code", digits[31:28], 4'hF);
    chk("dash_dp7", dps[7], 0);
    repeat (TMO / 2) @(negedge clk);
    chk("link_before_timeout", link_active, 1);
    repeat (TMO / 2 + 100) @(negedge clk);
    chk("link_after_timeout", link_active, 0);

    shift_bits(16'hA5A5, 0, 8);
    @(negedge clk); rst = 1'b1;
    model_clear();
    @(negedge clk);
    check_all_zero("midword_reset");
    repeat (2) @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    send_word(16'hEF30); drain();
    chk("after_reset_digits", digits, 32'h00010000);

    shift_bits(16'hDF6D, 0, 16);
    latch(1, 1'b1);
    shift_bits(16'hBF79, 1, 15);
    latch(0, 0); drain();
    chk("coincident_first", digits[23:20], 4'h2);
    chk("coincident_second", digits[27:24], 4'h3);

    carried = 0;
    for (int n = 0; n < 40; n++) begin
      sel = ~(8'b1 << $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) sel = 8'($urandom);
      seg = ($urandom_range(0, 9) == 0) ? 7'b0000001 : pat[$urandom_range(0, 9)];
      if ($urandom_range(0, 5) == 0) seg = 7'($urandom);
      w = {sel, 1'($urandom), seg};
      case ($urandom_range(0, 9))
        0: begin shift_bits(w, carried, 15 - carried); latch(0, 0); carried = 0; end
        1: begin shift_bit(1'($urandom)); shift_bits(w, carried, 16 - carried); latch(0, 0); carried = 0; end
        2: begin shift_bits(w, carried, 16 - carried); latch(1, 1'($urandom)); carried = 1; end
        default: begin shift_bits(w, carried, 16 - carried); latch(0, 0); carried = 0; end
      endcase
    end
    latch(0, 0);
    drain();
    chk("total_frame_done", cnt_fd, exp_fd);
    chk("total_sel_err", cnt_sel, exp_sel);
    chk("total_seg_err", cnt_seg, exp_seg);
    chk("total_len_err", cnt_len, exp_len);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
